// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcode, ALU op and decoded-bundle definitions for instr_decode_stage
package decode_pkg;

    localparam logic [3:0] INS_ADD  = 4'd0;
    localparam logic [3:0] INS_SUB  = 4'd1;
    localparam logic [3:0] INS_SLTI = 4'd2;
    localparam logic [3:0] INS_AND  = 4'd3;
    localparam logic [3:0] INS_OR   = 4'd4;
    localparam logic [3:0] INS_XOR  = 4'd5;
    localparam logic [3:0] INS_ANDI = 4'd6;
    localparam logic [3:0] INS_ORI  = 4'd7;
    localparam logic [3:0] INS_XORI = 4'd8;
    localparam logic [3:0] INS_ADDI = 4'd9;
    localparam logic [3:0] INS_SUBI = 4'd10;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SLT = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;

    typedef enum logic {
        EXT_ZERO = 1'b0,
        EXT_SIGN = 1'b1
    } ext_mode_e;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       is_imm;
        ext_mode_e  ext;
        logic       wr_en;
        logic       illegal;
    } decode_bundle_t;

endpackage

// File: rtl/instr_decode_stage_if.sv
// rtl/instr_decode_stage_if.sv - fetch-side and ALU-side handshake bundle; stat signals exist only with DECODE_STATS_EN
interface instr_decode_stage_if #(
    parameter int REG_W  = 4,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    localparam int INSTR_W = 4 + 3 * REG_W;

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         out_alu_op;
    logic               out_is_imm;
    logic [REG_W-1:0]   out_dst;
    logic [REG_W-1:0]   out_regb;
    logic [REG_W-1:0]   out_rega;
    logic [DATA_W-1:0]  out_imm;
    logic               out_wr_en;
    logic               out_illegal;
`ifdef DECODE_STATS_EN
    logic [CNT_W-1:0]   stat_instr;
    logic [CNT_W-1:0]   stat_illegal;
`else
    // Keeps CNT_W referenced when the counters are compiled out.
    if (CNT_W > 0) begin : g_cnt_unused
    end
`endif

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_alu_op, out_is_imm, out_dst,
               out_regb, out_rega, out_imm, out_wr_en, out_illegal
`ifdef DECODE_STATS_EN
        , output stat_instr, stat_illegal
`endif
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_alu_op, out_is_imm, out_dst,
               out_regb, out_rega, out_imm, out_wr_en, out_illegal
`ifdef DECODE_STATS_EN
        , input stat_instr, stat_illegal
`endif
    );

endinterface

// File: rtl/decode_lut.sv
// rtl/decode_lut.sv - combinational opcode to decoded-bundle table
module decode_lut
    import decode_pkg::*;
(
    input  logic [3:0]     i_opcode,
    output decode_bundle_t o_bundle
);

    always_comb begin
        o_bundle = '{alu_op: ALU_ADD, is_imm: 1'b0, ext: EXT_ZERO, wr_en: 1'b0, illegal: 1'b1};
        case (i_opcode)
            INS_ADD:  o_bundle = '{ALU_ADD, 1'b0, EXT_ZERO, 1'b1, 1'b0};
            INS_SUB:  o_bundle = '{ALU_SUB, 1'b0, EXT_ZERO, 1'b1, 1'b0};
            INS_SLTI: o_bundle = '{ALU_SLT, 1'b1, EXT_SIGN, 1'b1, 1'b0};
            INS_AND:  o_bundle = '{ALU_AND, 1'b0, EXT_ZERO, 1'b1, 1'b0};
            INS_OR:   o_bundle = '{ALU_OR,  1'b0, EXT_ZERO, 1'b1, 1'b0};
            INS_XOR:  o_bundle = '{ALU_XOR, 1'b0, EXT_ZERO, 1'b1, 1'b0};
            INS_ANDI: o_bundle = '{ALU_AND, 1'b1, EXT_ZERO, 1'b1, 1'b0};
            INS_ORI:  o_bundle = '{ALU_OR,  1'b1, EXT_ZERO, 1'b1, 1'b0};
            INS_XORI: o_bundle = '{ALU_XOR, 1'b1, EXT_ZERO, 1'b1, 1'b0};
            INS_ADDI: o_bundle = '{ALU_ADD, 1'b1, EXT_SIGN, 1'b1, 1'b0};
            INS_SUBI: o_bundle = '{ALU_SUB, 1'b1, EXT_SIGN, 1'b1, 1'b0};
            default:  ;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - registered valid/ready instruction decode stage; optional counters via DECODE_STATS_EN
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int REG_W  = 4,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
)
(
    input  logic                 CLK,
    input  logic                 RST_N,
    instr_decode_stage_if.slave  bus
);

    localparam int INSTR_W = 4 + 3 * REG_W;

    logic [3:0]        w_opcode;
    logic [REG_W-1:0]  w_dst;
    logic [REG_W-1:0]  w_immb;
    logic [REG_W-1:0]  w_rega;
    decode_bundle_t    w_bundle;
    logic              w_sign;
    logic [DATA_W-1:0] w_imm;
    logic              w_accept;
    logic              w_handoff;

    logic              r_valid;
    logic [3:0]        r_alu_op;
    logic              r_is_imm;
    logic [REG_W-1:0]  r_dst;
    logic [REG_W-1:0]  r_regb;
    logic [REG_W-1:0]  r_rega;
    logic [DATA_W-1:0] r_imm;
    logic              r_wr_en;
    logic              r_illegal;

    assign w_opcode = bus.in_instr[INSTR_W-1 -: 4];
    assign w_dst    = bus.in_instr[3*REG_W-1 -: REG_W];
    assign w_immb   = bus.in_instr[2*REG_W-1 -: REG_W];
    assign w_rega   = bus.in_instr[REG_W-1:0];

    decode_lut u_lut (
        .i_opcode (w_opcode),
        .o_bundle (w_bundle)
    );

    assign w_sign = (w_bundle.ext == EXT_SIGN) && w_immb[REG_W-1];

    always_comb begin
        w_imm = {DATA_W{w_sign}};
        w_imm[REG_W-1:0] = w_immb;
        if (w_bundle.illegal) begin
            w_imm = '0;
        end
    end

    // Ready depends only on the output side, never on in_instr.
    assign bus.in_ready = !r_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_handoff    = r_valid && bus.out_ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_valid   <= 1'b0;
            r_alu_op  <= '0;
            r_is_imm  <= 1'b0;
            r_dst     <= '0;
            r_regb    <= '0;
            r_rega    <= '0;
            r_imm     <= '0;
            r_wr_en   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_alu_op  <= w_bundle.alu_op;
            r_is_imm  <= w_bundle.is_imm;
            r_dst     <= w_dst;
            r_regb    <= w_immb;
            r_rega    <= w_rega;
            r_imm     <= w_imm;
            r_wr_en   <= w_bundle.wr_en;
            r_illegal <= w_bundle.illegal;
        end else if (w_handoff) begin
            r_valid   <= 1'b0;
        end
    end

    assign bus.out_valid   = r_valid;
    assign bus.out_alu_op  = r_alu_op;
    assign bus.out_is_imm  = r_is_imm;
    assign bus.out_dst     = r_dst;
    assign bus.out_regb    = r_regb;
    assign bus.out_rega    = r_rega;
    assign bus.out_imm     = r_imm;
    assign bus.out_wr_en   = r_wr_en;
    assign bus.out_illegal = r_illegal;

`ifdef DECODE_STATS_EN
    logic [CNT_W-1:0] r_stat_instr;
    logic [CNT_W-1:0] r_stat_illegal;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_stat_instr   <= '0;
            r_stat_illegal <= '0;
        end else if (w_accept) begin
            if (r_stat_instr != {CNT_W{1'b1}}) begin
                r_stat_instr <= r_stat_instr + 1'b1;
            end
            if (w_bundle.illegal && (r_stat_illegal != {CNT_W{1'b1}})) begin
                r_stat_illegal <= r_stat_illegal + 1'b1;
            end
        end
    end

    assign bus.stat_instr   = r_stat_instr;
    assign bus.stat_illegal = r_stat_illegal;
`else
    if (CNT_W > 0) begin : g_cnt_unused
    end
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - randomized and directed checks of instr_decode_stage against a queue-based model
module tb_instr_decode_stage;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    instr_decode_stage_if bus ();

    instr_decode_stage dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  alu;
        logic        is_imm;
        logic [3:0]  dst;
        logic [3:0]  regb;
        logic [3:0]  rega;
        logic [15:0] imm;
        logic        wr;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   alu_tab[11] = '{0, 1, 2, 3, 4, 5, 3, 4, 5, 0, 1};
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_pop   = 0;
    int   m_si    = 0;
    int   m_sil   = 0;
    logic acc;
    logic [15:0] words[8];

    function automatic exp_t model(input logic [15:0] w);
        exp_t e;
        int op;
        int f;
        op = int'(w[15:12]);
        f  = int'(w[7:4]);
        e.dst  = w[11:8];
        e.regb = w[7:4];
        e.rega = w[3:0];
        if (op > 10) begin
            e.alu = 4'd0; e.is_imm = 1'b0; e.imm = 16'd0; e.wr = 1'b0; e.ill = 1'b1;
        end else begin
            e.alu    = 4'(alu_tab[op]);
            e.is_imm = (op == 2) || (op >= 6);
            e.wr     = 1'b1;
            e.ill    = 1'b0;
            if (((op == 2) || (op == 9) || (op == 10)) && (f >= 8)) e.imm = 16'(f - 16);
            else e.imm = 16'(f);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic compare();
        if (q.size() > 0) begin
            chk("out_valid", bus.out_valid, 1);
            chk("out_alu_op", bus.out_alu_op, q[0].alu);
            chk("out_is_imm", bus.out_is_imm, q[0].is_imm);
            chk("out_dst", bus.out_dst, q[0].dst);
            chk("out_regb", bus.out_regb, q[0].regb);
            chk("out_rega", bus.out_rega, q[0].rega);
            chk("out_imm", bus.out_imm, q[0].imm);
            chk("out_wr_en", bus.out_wr_en, q[0].wr);
            chk("out_illegal", bus.out_illegal, q[0].ill);
        end else begin
            chk("out_valid_idle", bus.out_valid, 0);
        end
`ifdef DECODE_STATS_EN
        chk("stat_instr", bus.stat_instr, m_si);
        chk("stat_illegal", bus.stat_illegal, m_sil);
`endif
    endtask

    task automatic step(input logic v, input logic [15:0] w, input logic rdy, output logic a);
        logic exp_rdy;
        @(negedge CLK);
        compare();
        bus.in_valid  = v;
        bus.in_instr  = w;
        bus.out_ready = rdy;
        #1;
        exp_rdy = (q.size() == 0) || rdy;
        chk("in_ready", bus.in_ready, exp_rdy);
        if ((q.size() > 0) && rdy) begin
            void'(q.pop_front());
            n_pop++;
        end
        a = v && exp_rdy;
        if (a) begin
            q.push_back(model(w));
            if (m_si < 65535) m_si++;
            if ((w[15:12] > 4'd10) && (m_sil < 65535)) m_sil++;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_alu"}, bus.out_alu_op, 0);
        chk({tag, "_isimm"}, bus.out_is_imm, 0);
        chk({tag, "_dst"}, bus.out_dst, 0);
        chk({tag, "_regb"}, bus.out_regb, 0);
        chk({tag, "_rega"}, bus.out_rega, 0);
        chk({tag, "_imm"}, bus.out_imm, 0);
        chk({tag, "_wr"}, bus.out_wr_en, 0);
        chk({tag, "_ill"}, bus.out_illegal, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
`ifdef DECODE_STATS_EN
        chk({tag, "_stat_instr"}, bus.stat_instr, 0);
        chk({tag, "_stat_illegal"}, bus.stat_illegal, 0);
`endif
    endtask

    initial begin
        RST_N = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.out_ready = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check_zero("reset");
        RST_N = 1'b1;

        // Directed decodes with hand-computed values.
        step(1, 16'h93F2, 1, acc);
        step(1, 16'h61F0, 1, acc);
        chk("addi_alu", bus.out_alu_op, 0);
        chk("addi_isimm", bus.out_is_imm, 1);
        chk("addi_dst", bus.out_dst, 3);
        chk("addi_rega", bus.out_rega, 2);
        chk("addi_imm", bus.out_imm, 16'hFFFF);
        chk("addi_wr", bus.out_wr_en, 1);
        step(1, 16'h2580, 1, acc);
        chk("andi_alu", bus.out_alu_op, 3);
        chk("andi_imm", bus.out_imm, 16'h000F);
        step(0, 16'h0000, 1, acc);
        chk("slti_alu", bus.out_alu_op, 2);
        chk("slti_imm", bus.out_imm, 16'hFFF8);
        step(0, 16'h0000, 1, acc);

        // Backpressure: hold the first decode while the consumer stalls.
        n_pop = 0;
        step(1, 16'h0123, 1, acc);
        chk("bp_first_acc", acc, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 16'h1456, 0, acc);
            chk("bp_stall_acc", acc, 0);
            chk("bp_hold_dst", bus.out_dst, 1);
            chk("bp_hold_regb", bus.out_regb, 2);
            chk("bp_hold_rega", bus.out_rega, 3);
        end
        acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) step(1, 16'h1456, 1, acc);
        chk("bp_second_acc", acc, 1);
        acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) step(1, 16'h4789, 1, acc);
        chk("bp_third_acc", acc, 1);
        step(0, 16'h0000, 1, acc);
        step(0, 16'h0000, 1, acc);
        chk("bp_drain_count", n_pop, 3);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                 $urandom_range(0, 3) != 0, acc);
        end

        // Reset while a result is held.
        step(1, 16'h3ABC, 0, acc);
        step(1, 16'h4DEF, 0, acc);
        chk("pre_reset_valid", bus.out_valid, 1);
        RST_N = 1'b0;
        #1;
        check_zero("midreset");
        q.delete();
        m_si = 0;
        m_sil = 0;
        bus.in_valid = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;

        // Eight back-to-back words, first one illegal.
        words[0] = 16'hB123;
        for (int i = 1; i < 8; i++) words[i] = {4'($urandom_range(0, 10)), 12'($urandom_range(0, 4095))};
        n_pop = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, words[i], 1, acc);
            chk("burst_acc", acc, 1);
            if (i == 1) begin
                chk("ill_flag", bus.out_illegal, 1);
                chk("ill_wr", bus.out_wr_en, 0);
                chk("ill_alu", bus.out_alu_op, 0);
                chk("ill_imm", bus.out_imm, 0);
                chk("ill_dst", bus.out_dst, 1);
                chk("ill_rega", bus.out_rega, 3);
            end
        end
        step(0, 16'h0000, 1, acc);
        chk("burst_outputs", n_pop, 8);
`ifdef DECODE_STATS_EN
        chk("burst_stat_instr", bus.stat_instr, 8);
        chk("burst_stat_illegal", bus.stat_illegal, 1);
`endif
        step(0, 16'h0000, 1, acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered, handshaked instruction decode stage for the ALU datapath. It accepts one instruction word per transfer and splits it into opcode, destination, source and immediate fields. The opcode maps to an ALU operation, an immediate-select flag, an immediate-extension mode and a legality flag. Results sit in a single valid/ready pipeline register between instruction fetch and the register-file/ALU wrapper. Register-field width and datapath width are parametrised.

## Interface
- REG_W, 4, width of each register/immediate field
- DATA_W, 16, ALU operand width; immediate is extended to this; must be ≥ REG_W
- CNT_W, 16, width of statistics counters (used only with DECODE_STATS_EN)
- Derived: INSTR_W = 4 + 3*REG_W
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction word present
- in_ready  out  1  stage can accept
- in_instr  in  INSTR_W  {opcode[3:0], dst, immb/regb, rega}, MSB to LSB
- out_valid  out  1  decoded result present
- out_ready  in  1  consumer accepts
- out_alu_op  out  4  ALU opcode: ADD=0, SUB=1, SLT=2, AND=3, OR=4, XOR=5
- out_is_imm  out  1  operand B is out_imm, not regb
- out_dst, out_regb, out_rega  out  REG_W each  register indices
- out_imm  out  DATA_W  extended immediate (immb field)
- out_wr_en  out  1  destination write enable
- out_illegal  out  1  opcode 11–15
- stat_instr, stat_illegal  out  CNT_W each  counters (DECODE_STATS_EN only)

## Operation
- Opcode map: 0 ADD, 1 SUB, 2 SLTI, 3 AND, 4 OR, 5 XOR, 6 ANDI, 7 ORI, 8 XORI, 9 ADDI, 10 SUBI.
  - ALU op: ADD/ADDI→ADD; SUB/SUBI→SUB; SLTI→SLT; AND/ANDI→AND; OR/ORI→OR; XOR/XORI→XOR.
  - is_imm=1 for opcodes 2, 6–10; 0 otherwise.
- Immediate extension:
  - Sign-extended for SLTI, ADDI, SUBI.
  - Zero-extended for ANDI, ORI, XORI.
  - Register forms: out_imm = zero-extended field, ignored downstream.
- Fields dst, regb and rega pass through unchanged.
- Illegal opcodes 11–15:
  - out_illegal=1, out_wr_en=0, alu_op=ADD, is_imm=0, out_imm=0.
  - Field passthrough still occurs.
- Legal opcodes: out_wr_en=1, out_illegal=0.
- Decode is combinational on in_instr and is captured into the output register on accept.

## Timing
- Accept when in_valid && in_ready. Output handoff when out_valid && out_ready.
- in_ready = !out_valid || out_ready, so the stage sustains 1 instruction/cycle under continuous out_ready.
- Latency is 1 cycle: a word accepted at edge N appears on out_* after edge N.
- Output registers change only on accept. Under out_valid && !out_ready, all out_* hold stable.
- out_valid:
  - Set on accept.
  - Cleared on handoff without a simultaneous accept.
  - Simultaneous handoff and accept: stays 1 with the new contents.
- No combinational path from in_instr to out_*. in_ready depends combinationally on out_ready only.
- Reset, asynchronous on RST_N low:
  - out_valid=0, every out_* field=0, counters=0.
  - Reset mid-transfer discards the held instruction; no partial output.
  - in_ready=1 while in reset once RST_N is released at the next edge.

## Configuration
- DECODE_STATS_EN defined:
  - stat_instr increments on each accept.
  - stat_illegal increments on each accept with an illegal opcode.
  - Both saturate at 2^CNT_W−1 and reset to 0.
- DECODE_STATS_EN undefined: the stat ports and counter logic are absent. All other behaviour is identical.

## Structure
- Shared package decode_pkg holds:
  - opcode constants (INS_ADD … INS_SUBI)
  - ALU op constants (ALU_ADD … ALU_XOR)
  - enum for extension mode {EXT_ZERO, EXT_SIGN}
  - decoded-bundle struct {alu_op, is_imm, ext, wr_en, illegal}
- One sub-module, decode_lut: a purely combinational opcode→bundle table. The top holds the extension logic, the pipeline register and the counters.

## Test plan
- REG_W=4, DATA_W=16: ADDI 0x93F2 → alu_op=0, is_imm=1, dst=3, rega=2, imm=0xFFFF, wr_en=1.
- ANDI 0x61F0 → alu_op=3, imm=0x000F; SLTI 0x2580 → alu_op=2, imm=0xFFF8.
- Illegal opcode 0xB123 → illegal=1, wr_en=0, alu_op=0, imm=0; with DECODE_STATS_EN, stat_illegal=1.
- Backpressure: stream 0x0123, 0x1456, 0x4789 with out_ready low for 3 cycles after the first → outputs hold 0x0123 decode, in_ready=0, then all three drain in order with none lost or duplicated.
- Back-to-back with out_ready=1 for 8 words → 8 outputs on 8 consecutive cycles; stat_instr=8.
- Assert RST_N low with out_valid=1 → out_valid=0 and all outputs 0 immediately. After release, the first new word appears one cycle after accept.
